// File: rtl/hazard_scoreboard_pkg.sv
// ============================================================================
// hazard_scoreboard_pkg : shared codes, slot record and helpers for the
//                         hazard/forwarding scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_scoreboard_pkg;

    localparam int SB_TW = 3;
    localparam int SB_KW = 3;
    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_GRF = '0;

    // Kind 0 is reserved so that "no forward" never aliases a real kind.
    localparam logic [SB_KW-1:0] KIND_NONE = 3'd0;
    localparam logic [SB_KW-1:0] KIND_ALU  = 3'd1;
    localparam logic [SB_KW-1:0] KIND_DM   = 3'd2;
    localparam logic [SB_KW-1:0] KIND_PC   = 3'd3;
    localparam logic [SB_KW-1:0] KIND_HI   = 3'd4;
    localparam logic [SB_KW-1:0] KIND_LO   = 3'd5;
    localparam logic [SB_KW-1:0] KIND_CP0  = 3'd6;

    localparam logic [SB_TW-1:0] TNEW_NONE = 3'd0;
    localparam logic [SB_TW-1:0] TNEW_ALU  = 3'd1;
    localparam logic [SB_TW-1:0] TNEW_DM   = 3'd2;
    localparam logic [SB_TW-1:0] TUSE_BR   = 3'd0;
    localparam logic [SB_TW-1:0] TUSE_ALU  = 3'd1;
    localparam logic [SB_TW-1:0] TUSE_ST   = 3'd2;

    typedef struct packed {
        logic             valid;
        logic [4:0]       waddr;
        logic [SB_TW-1:0] tnew;
        logic [SB_KW-1:0] kind;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    // Advance a record one stage: Tnew counts down and sticks at zero.
    function automatic slot_t slot_age(input slot_t s);
        slot_t r;
        r = s;
        if (s.tnew != '0) begin
            r.tnew = s.tnew - SB_TW'(1);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_lookup.sv
// ============================================================================
// scoreboard_lookup : youngest-first priority match of one read address
//                     against scoreboard slots START..DEPTH-1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module scoreboard_lookup
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int START = 0
) (
    input  logic [4:0]       addr,
    input  slot_t            slots [DEPTH],
    output logic             hit,
    output logic [SEL_W-1:0] idx,
    output logic [SB_TW-1:0] tnew,
    output logic [SB_KW-1:0] kind
);

    // Scan oldest to youngest so the last assignment is the youngest match.
    always_comb begin
        hit  = 1'b0;
        idx  = SEL_GRF;
        tnew = '0;
        kind = KIND_NONE;
        for (int i = DEPTH - 1; i >= START; i--) begin
            if (addr != 5'd0 && slots[i].valid && slots[i].waddr == addr) begin
                hit  = 1'b1;
                idx  = SEL_W'(i);
                tnew = slots[i].tnew;
                kind = slots[i].kind;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// hazard_scoreboard : shift-register scoreboard issuing D-stage stall,
//                     D/E forward selects and the mult/div busy interlock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NPORT   = 2,
    parameter int DEPTH   = 3,
    parameter int TW      = SB_TW,
    parameter int KW      = SB_KW,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NPORT*5-1:0]    d_raddr,
    input  logic [NPORT*TW-1:0]   d_tuse,
    input  logic                  d_wen,
    input  logic [4:0]            d_waddr,
    input  logic [TW-1:0]         d_tnew,
    input  logic [KW-1:0]         d_kind,
    input  logic                  d_md_start,
    input  logic                  d_md_div,
    input  logic                  d_uses_hilo,
    input  logic                  flush,
    input  logic [NPORT*5-1:0]    e_raddr,
    output logic                  stall,
    output logic [NPORT*2-1:0]    fwd_d_sel,
    output logic [NPORT*KW-1:0]   fwd_d_kind,
    output logic [NPORT*2-1:0]    fwd_e_sel,
    output logic [NPORT*KW-1:0]   fwd_e_kind,
    output logic                  md_busy
);

    localparam int MD_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int MDW    = $clog2(MD_MAX + 1);

    slot_t            r_slot [DEPTH];
    logic [MDW-1:0]   r_md_cnt;
    logic [NPORT-1:0] w_port_stall;

    assign md_busy = (r_md_cnt != '0);
    assign stall   = (|w_port_stall) || (d_uses_hilo && md_busy);

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic             w_d_hit;
        logic [SEL_W-1:0] w_d_idx;
        logic [SB_TW-1:0] w_d_tnew;
        logic [SB_KW-1:0] w_d_kind;
        logic             w_d_fwd;
        logic             w_e_hit;
        logic [SEL_W-1:0] w_e_idx;
        logic [SB_TW-1:0] w_e_tnew_unused;
        logic [SB_KW-1:0] w_e_kind;

        scoreboard_lookup #(.DEPTH(DEPTH), .START(0)) u_d_lookup (
            .addr  (d_raddr[5*p +: 5]),
            .slots (r_slot),
            .hit   (w_d_hit),
            .idx   (w_d_idx),
            .tnew  (w_d_tnew),
            .kind  (w_d_kind)
        );

        // Slot 0 is the E instruction itself, so E operands start at M.
        scoreboard_lookup #(.DEPTH(DEPTH), .START(1)) u_e_lookup (
            .addr  (e_raddr[5*p +: 5]),
            .slots (r_slot),
            .hit   (w_e_hit),
            .idx   (w_e_idx),
            .tnew  (w_e_tnew_unused),
            .kind  (w_e_kind)
        );

        assign w_port_stall[p] = w_d_hit && (w_d_tnew > d_tuse[TW*p +: TW]);
        assign w_d_fwd = w_d_hit && !w_port_stall[p] && (w_d_idx != SEL_GRF)
                         && (w_d_tnew == '0);

        assign fwd_d_sel[2*p +: 2]   = w_d_fwd ? w_d_idx  : SEL_GRF;
        assign fwd_d_kind[KW*p +: KW] = w_d_fwd ? w_d_kind : KIND_NONE;
        assign fwd_e_sel[2*p +: 2]   = w_e_hit ? w_e_idx  : SEL_GRF;
        assign fwd_e_kind[KW*p +: KW] = w_e_hit ? w_e_kind : KIND_NONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= SLOT_BUBBLE;
            end
            r_md_cnt <= '0;
        end else begin
            if (flush || stall) begin
                r_slot[0] <= SLOT_BUBBLE;
            end else begin
                r_slot[0] <= '{valid: d_wen && (d_waddr != 5'd0),
                               waddr: d_waddr,
                               tnew:  d_tnew,
                               kind:  d_kind};
            end
            for (int i = 1; i < DEPTH; i++) begin
                r_slot[i] <= flush ? SLOT_BUBBLE : slot_age(r_slot[i-1]);
            end
            // Flush leaves the counter alone: an issued mult/div always completes.
            if (d_md_start && !stall && !flush) begin
                r_md_cnt <= d_md_div ? MDW'(DIV_LAT) : MDW'(MUL_LAT);
            end else if (r_md_cnt != '0) begin
                r_md_cnt <= r_md_cnt - MDW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// tb_hazard_scoreboard : directed self-checking bench for hazard_scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    localparam logic [2:0] K_ALU = 3'd1;
    localparam logic [2:0] K_DM  = 3'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  d_raddr;
    logic [5:0]  d_tuse;
    logic        d_wen;
    logic [4:0]  d_waddr;
    logic [2:0]  d_tnew;
    logic [2:0]  d_kind;
    logic        d_md_start;
    logic        d_md_div;
    logic        d_uses_hilo;
    logic        flush;
    logic [9:0]  e_raddr;
    logic        stall;
    logic [3:0]  fwd_d_sel;
    logic [5:0]  fwd_d_kind;
    logic [3:0]  fwd_e_sel;
    logic [5:0]  fwd_e_kind;
    logic        md_busy;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard u_dut (
        .clk         (clk),
        .reset       (reset),
        .d_raddr     (d_raddr),
        .d_tuse      (d_tuse),
        .d_wen       (d_wen),
        .d_waddr     (d_waddr),
        .d_tnew      (d_tnew),
        .d_kind      (d_kind),
        .d_md_start  (d_md_start),
        .d_md_div    (d_md_div),
        .d_uses_hilo (d_uses_hilo),
        .flush       (flush),
        .e_raddr     (e_raddr),
        .stall       (stall),
        .fwd_d_sel   (fwd_d_sel),
        .fwd_d_kind  (fwd_d_kind),
        .fwd_e_sel   (fwd_e_sel),
        .fwd_e_kind  (fwd_e_kind),
        .md_busy     (md_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic [2:0] tu0, input logic [2:0] tu1,
                         input logic wen, input logic [4:0] wa,
                         input logic [2:0] tn, input logic [2:0] kd,
                         input logic mds, input logic mdd, input logic hilo);
        d_raddr     = {ra1, ra0};
        d_tuse      = {tu1, tu0};
        d_wen       = wen;
        d_waddr     = wa;
        d_tnew      = tn;
        d_kind      = kd;
        d_md_start  = mds;
        d_md_div    = mdd;
        d_uses_hilo = hilo;
        e_raddr     = '0;
        flush       = 1'b0;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #12;
        check_eq("rst_stall", stall, 0);
        check_eq("rst_busy", md_busy, 0);
        check_eq("rst_fwd_d", fwd_d_sel, 0);
        check_eq("rst_fwd_e", fwd_e_sel, 0);
        reset = 1'b0;
        tick();

        // addu $3 then beq $3: one stall, then forward from M
        drive(0, 0, 0, 0, 1, 3, 1, K_ALU, 0, 0, 0);
        #1 check_eq("addu_nostall", stall, 0);
        tick();
        drive(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check_eq("beq_stall", stall, 1);
        tick();
        #1 check_eq("beq_release", stall, 0);
        check_eq("beq_fwd_sel", fwd_d_sel[1:0], 1);
        check_eq("beq_fwd_kind", fwd_d_kind[2:0], K_ALU);
        tick();
        drain();

        // lw $5 then addu $6 <- $5 (tuse 1)
        drive(0, 0, 0, 0, 1, 5, 2, K_DM, 0, 0, 0);
        tick();
        drive(5, 0, 1, 0, 1, 6, 1, K_ALU, 0, 0, 0);
        #1 check_eq("lw_use_stall", stall, 1);
        tick();
        #1 check_eq("lw_use_release", stall, 0);
        check_eq("lw_use_dsel", fwd_d_sel[1:0], 0);
        tick();
        drive(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_raddr = {5'd0, 5'd5};
        #1 check_eq("lw_e_sel", fwd_e_sel[1:0], 2);
        check_eq("lw_e_kind", fwd_e_kind[2:0], K_DM);
        check_eq("lw_d_sel_w", fwd_d_sel[1:0], 2);
        tick();
        drain();

        // $4 produced in W (DM) and M (ALU): youngest wins
        drive(0, 0, 0, 0, 1, 4, 2, K_DM, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 4, 1, K_ALU, 0, 0, 0);
        tick();
        idle();
        tick();
        drive(0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        e_raddr = {5'd4, 5'd0};
        #1 check_eq("young_stall", stall, 0);
        check_eq("young_dsel", fwd_d_sel[3:2], 1);
        check_eq("young_dkind", fwd_d_kind[5:3], K_ALU);
        check_eq("young_esel", fwd_e_sel[3:2], 1);
        check_eq("young_ekind", fwd_e_kind[5:3], K_ALU);
        tick();
        drain();

        // mult, unrelated addu, then mflo held until busy drops
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        #1 check_eq("mult_busy0", md_busy, 0);
        tick();
        drive(7, 0, 1, 0, 1, 8, 1, K_ALU, 0, 0, 0);
        #1 check_eq("addu_behind_mult", stall, 0);
        check_eq("mult_busy1", md_busy, 1);
        tick();
        drive(0, 0, 0, 0, 1, 9, 1, K_ALU, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            #1 check_eq("mflo_stall", stall, 1);
            check_eq("mflo_busy", md_busy, 1);
            tick();
        end
        #1 check_eq("mflo_release", stall, 0);
        check_eq("mult_done", md_busy, 0);
        tick();
        drain();

        // write to $0 never creates a hazard
        drive(0, 0, 0, 0, 1, 0, 2, K_DM, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check_eq("r0_stall", stall, 0);
        check_eq("r0_sel", fwd_d_sel, 0);
        tick();
        drain();

        // flush while stalled behind lw
        drive(0, 0, 0, 0, 1, 11, 2, K_DM, 0, 0, 0);
        tick();
        drive(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check_eq("flush_pre_stall", stall, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        e_raddr = {5'd0, 5'd11};
        #1 check_eq("flush_stall", stall, 0);
        check_eq("flush_dsel", fwd_d_sel, 0);
        check_eq("flush_esel", fwd_e_sel, 0);
        tick();
        drain();

        // div loaded on the mult's final decrement, then async reset
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        idle();
        repeat (4) tick();
        #1 check_eq("mult_last", md_busy, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        #1 check_eq("div_loaded", md_busy, 1);
        drive(0, 0, 0, 0, 1, 10, 1, K_ALU, 0, 0, 0);
        tick();
        idle();
        tick();
        drive(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1 check_eq("div_stall", stall, 1);
        check_eq("div_fwd", fwd_d_sel[1:0], 1);
        check_eq("div_busy", md_busy, 1);
        #2 reset = 1'b1;
        #1 check_eq("arst_stall", stall, 0);
        check_eq("arst_busy", md_busy, 0);
        check_eq("arst_dsel", fwd_d_sel, 0);
        check_eq("arst_dkind", fwd_d_kind, 0);
        idle();
        #5 reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the pipelined MIPS CPU.
- Replaces per-stage instruction re-decoding with a registered shift-register scoreboard that records every in-flight register write.
  - Each record holds destination, per-producer Tnew countdown and result kind.
- Issues the D-stage stall, D-stage forward selects for NPORT read ports, E-stage forward selects, and a multiply/divide busy interlock.
- Sits beside the datapath; the instruction decoder drives it.

Parameters:
- NPORT, 2, number of GPR read ports checked in D and in E
- DEPTH, 3, tracked stages after D: slot 0 = E, slot 1 = M, slot DEPTH-1 = W
- TW, 3, width of Tnew/Tuse fields
- KW, 3, width of result-kind code (ALU/DM/PC/HI/LO/CP0)
- MUL_LAT, 5, busy cycles for mult/multu
- DIV_LAT, 10, busy cycles for div/divu

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- d_raddr  in  NPORT*5  D-stage read addresses, port p at [5p+4:5p]
- d_tuse  in  NPORT*TW  Tuse per D port
- d_wen  in  1  D instruction writes a GPR
- d_waddr  in  5  D destination register
- d_tnew  in  TW  Tnew at entry to E
- d_kind  in  KW  result kind of D instruction
- d_md_start  in  1  D is mult/div
- d_md_div  in  1  1 = div latency, 0 = mult latency
- d_uses_hilo  in  1  D reads or writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
- flush  in  1  exception/eret flush, synchronous
- e_raddr  in  NPORT*5  E-stage read addresses
- stall  out  1  freeze PC and D, bubble into E
- fwd_d_sel  out  NPORT*2  0 = GRF, else slot index (1 = M, 2 = W)
- fwd_d_kind  out  NPORT*KW  kind of forwarding slot
- fwd_e_sel  out  NPORT*2  as fwd_d_sel, for E operands
- fwd_e_kind  out  NPORT*KW  kind of forwarding slot
- md_busy  out  1  md counter non-zero

Behaviour:
- Slot record: {valid, waddr[4:0], tnew[TW-1:0], kind[KW-1:0]}. Reset clears all slots; md counter = 0.
- Stall, fwd_* and md_busy are combinational from registered state plus current inputs, so they read 0 directly after reset.
- Every clock, slot[i+1] <= slot[i] with tnew saturating-decremented at 0. Old slot[DEPTH-1] retires.
- slot[0] loads {d_wen && d_waddr!=0, d_waddr, d_tnew, d_kind} when !stall && !flush; otherwise it loads a bubble (valid = 0).
- flush: all slots load bubble next cycle. Flush has priority over stall. The md counter is unaffected: an in-flight mult/div completes.
- D lookup, per port p with addr != 0:
  - Scan slots 0..DEPTH-1, youngest first; the first valid slot with waddr == addr is the producer.
  - If producer.tnew > d_tuse[p]: stall for that port.
  - Else, if slot index ≥ 1 and tnew == 0: fwd_d_sel = index, fwd_d_kind = kind.
  - Else: fwd_d_sel = 0. A producer in slot 0 is never a D forward source.
  - Addr 0 or no match: sel 0, kind 0.
- E lookup, per port: scan slots 1..DEPTH-1, youngest first, using the first match regardless of tnew. Slot 0 is the E instruction itself and is excluded.
- md counter:
  - On clock with d_md_start && !stall && !flush: load MUL_LAT or DIV_LAT.
  - Else decrement while non-zero.
  - md_busy = (counter != 0).
- stall = any port stall OR (d_uses_hilo && md_busy).
- A load that starts simultaneously with a final decrement takes the load.

Decomposition:
- Shared package holds:
  - KIND_* codes (ALU, DM, PC, HI, LO, CP0)
  - slot record typedef
  - SEL_GRF = 0
  - TNEW/TUSE constants
- One sub-module, scoreboard_lookup: a combinational youngest-first priority match over slots, parameterised by start slot.
  - Instantiated 2*NPORT times: D ports start at slot 0, E ports start at slot 1.

Test Plan:
- addu $3 (tnew 1, ALU) issued, then beq $3 in D (tuse 0): 1 stall cycle. Next cycle fwd_d_sel[0] = 1, kind ALU.
- lw $5 (tnew 2, DM), then addu reading $5 (tuse 1): stall for 1 cycle, then fwd_d_sel = 0. In E, fwd_e_sel = 2, kind DM.
- Producers $4 in M (ALU) and $4 in W (DM), D reads $4: fwd_d_sel = 1. The youngest producer wins.
- mult, then mflo at MUL_LAT = 5: md_busy for 5 cycles. mflo stalls until md_busy = 0; an unrelated addu behind the mult is not stalled.
- Write to $0 (tnew 2), read $0 (tuse 0): no stall, fwd_d_sel = 0.
- flush asserted while stall = 1 with lw in E: next cycle all slots invalid, stall = 0.
- Reset asserted mid-div: stall, md_busy and fwd_* go to 0 asynchronously.
